mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access stage sitting directly downstream of the execute stage.
- Consumes the instruction word, the ALU result (effective address or computed value) and the store operand.
- For loads and stores, runs a req/ack transaction on the data-memory bus and stalls upstream until the transaction completes; for all other instructions, passes the ALU result through to writeback.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, maximum cycles in BUSY without MemAck before the bus error fires; legal range 2..255.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous reset, active-high
- Valid  in  1  Ins/Result/Rdata2 hold a live instruction
- Ins  in  32  instruction word; Op = Ins[31:26], Rt = Ins[20:16]
- Result  in  32  execute-stage result; the effective address for loads and stores
- Rdata2  in  32  store data (rt)
- Stall  out  1  upstream must hold Ins/Result/Rdata2/Valid stable
- MemReq  out  1  bus request
- MemWe  out  1  1 = store, 0 = load
- MemAddr  out  32  word address, {addr[31:2], 2'b00}
- MemBe  out  4  byte enables
- MemWdata  out  32  store data, lane-aligned
- MemAck  in  1  single-cycle completion strobe
- MemRdata  in  32  load data, valid when MemAck = 1
- WbValid  out  1  one-cycle pulse; Wdata/WbReg valid
- WbReg  out  5  destination register (rt for loads; Ins[15:11] otherwise, 0 for stores)
- Wdata  out  32  writeback data
- AddrErr  out  1  one-cycle pulse on a misaligned access
- BusErr  out  1  one-cycle pulse on a timeout
- BadAddr  out  32  address of the last faulting access; holds until the next fault

Behaviour:
- Reset values: all outputs 0; FSM state = IDLE; timeout counter = 0.
- Memory ops:
  - Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores: SB 0x28, SH 0x29, SW 0x2B.
  - Any other Op is a non-memory instruction.
- Byte order and enables (little-endian, lane = addr[1:0]):
  - Byte: MemBe = 1 << lane.
  - Half: MemBe = 4'b0011 << lane.
  - Word: MemBe = 4'b1111.
- Store data: MemWdata = Rdata2 replicated into the addressed lane(s).
- Load data: extract the addressed lane(s) from MemRdata. LB and LH sign-extend; LBU and LHU zero-extend.
- Alignment: a half access requires addr[0] = 0; a word access requires addr[1:0] = 0.
- FSM states: IDLE, BUSY.
- IDLE, Valid, non-memory op: the next edge registers WbValid = 1 and Wdata = Result. Latency 1. Stall = 0.
- IDLE, Valid, memory op, misaligned:
  - No bus request is issued.
  - Next edge: AddrErr = 1, BadAddr = addr, WbValid = 0.
  - Stall = 0.
- IDLE, Valid, aligned memory op:
  - Stall = 1 in the same cycle (combinational).
  - Next edge: register MemAddr/MemBe/MemWdata/MemWe, the load kind and WbReg; MemReq = 1; counter = 0; go to BUSY.
- BUSY:
  - MemReq and all bus outputs stay stable.
  - Stall = !MemAck.
  - The counter increments each cycle.
- BUSY, MemAck = 1:
  - Next edge: MemReq = 0; go to IDLE.
  - Loads: WbValid = 1 with the extracted data.
  - Stores: WbValid = 1, WbReg = 0, Wdata = 0.
- BUSY, counter = TIMEOUT-1 and MemAck = 0:
  - Next edge: MemReq = 0, BusErr = 1, BadAddr = MemAddr, WbValid = 0; go to IDLE.
  - Stall = 0 in that cycle.
- Simultaneous MemAck and timeout: MemAck wins; no BusErr.
- Minimum load latency: request accepted at edge N, MemAck in cycle N+1, WbValid high after edge N+2.
- Back-to-back: a new instruction presented in the cycle after MemAck is accepted from IDLE with no bubble.
- MemAck while in IDLE (late ack after a timeout or reset): ignored.
- RST mid-transaction: MemReq drops at that edge, no WbValid, state = IDLE.
- Valid = 0 in IDLE: no action; all pulse outputs 0.

Decomposition:
- Shared package (common_param): memory opcodes LB/LH/LW/LBU/LHU/SB/SH/SW and the FSM state encodings.
- One natural sub-module: mem_lane_align, purely combinational. It generates MemBe and MemWdata from size, lane and store data, and extracts and extends load data from MemRdata. It is used on both the store and load paths.

Test Plan:
- ALU pass-through: Valid, Op = 0 (ADD), Result = 0x1234_5678, Ins[15:11] = 5 -> one cycle later WbValid = 1, WbReg = 5, Wdata = 0x1234_5678, MemReq never asserted.
- SB: Result = 0x0000_0103, Rdata2 = 0x0000_00AB -> MemAddr = 0x0000_0100, MemBe = 4'b1000, MemWdata = 0xABAB_ABAB, MemWe = 1. Ack after 3 cycles -> Stall released in the ack cycle, WbValid pulse with WbReg = 0.
- LH vs LHU: addr 0x202, MemRdata = 0x8001_7FFF -> LH gives Wdata = 0xFFFF_8001; LHU gives 0x0000_8001. LW with immediate ack -> WbValid exactly 2 edges after acceptance.
- Misaligned LW: Result = 0x0000_0006 -> AddrErr one pulse, BadAddr = 0x0000_0006, no MemReq, no WbValid, Stall = 0.
- Timeout with TIMEOUT = 4: never ack -> MemReq high 4 cycles, then BusErr pulse, MemReq = 0. A late MemAck afterwards is ignored. A repeat run with ack on the 4th cycle -> WbValid and no BusErr.
- Reset in BUSY: assert RST for 1 cycle mid-load -> MemReq = 0, all outputs 0 after that edge. A subsequent MemAck produces no WbValid.

Source files
------------

// File: rtl/common_param.sv
// rtl/common_param.sv - shared opcodes, access sizes and FSM states for mem_access
package common_param;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    mem_size_e size;
    logic      sext;
  } mem_op_t;

  // Classify an opcode; non-memory ops come back with both is_load and is_store clear.
  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t d;
    d.is_load  = 1'b0;
    d.is_store = 1'b0;
    d.size     = SZ_WORD;
    d.sext     = 1'b0;
    case (op)
      OP_LB:  begin d.is_load  = 1'b1; d.size = SZ_BYTE; d.sext = 1'b1; end
      OP_LH:  begin d.is_load  = 1'b1; d.size = SZ_HALF; d.sext = 1'b1; end
      OP_LW:  begin d.is_load  = 1'b1; d.size = SZ_WORD; end
      OP_LBU: begin d.is_load  = 1'b1; d.size = SZ_BYTE; end
      OP_LHU: begin d.is_load  = 1'b1; d.size = SZ_HALF; end
      OP_SB:  begin d.is_store = 1'b1; d.size = SZ_BYTE; end
      OP_SH:  begin d.is_store = 1'b1; d.size = SZ_HALF; end
      OP_SW:  begin d.is_store = 1'b1; d.size = SZ_WORD; end
      default: ;
    endcase
    return d;
  endfunction

  // Halves need an even address, words a 4-byte aligned one; bytes are always fine.
  function automatic logic is_aligned(input mem_size_e size, input logic [1:0] lane);
    logic ok;
    case (size)
      SZ_HALF: ok = ~lane[0];
      SZ_WORD: ok = (lane == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and lane extraction for loads
module mem_lane_align
  import common_param::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sext,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Little-endian: lane 0 is bits 7:0; loads shift the addressed lane down to bit 0.
  always_comb begin
    shifted = rd_data >> {lane, 3'b000};
    be      = 4'b1111;
    wdata   = st_data;
    ld_data = shifted;
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << lane;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be      = 4'b0011 << lane;
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage with req/ack bus, alignment and timeout faults
module mem_access
  import common_param::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBe,
  output logic [31:0] MemWdata,
  input  logic        MemAck,
  input  logic [31:0] MemRdata,
  output logic        WbValid,
  output logic [4:0]  WbReg,
  output logic [31:0] Wdata,
  output logic        AddrErr,
  output logic        BusErr,
  output logic [31:0] BadAddr
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  mem_size_e   size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  lane_q, lane_d;
  logic [4:0]  dest_q, dest_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic        stall_c;

  mem_op_t     dec;
  logic        is_mem;
  logic        aligned;
  logic [1:0]  al_size;
  logic [1:0]  al_lane;
  logic        al_sext;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld;
  logic        unused_ins;

  assign dec        = decode_op(Ins[31:26]);
  assign is_mem     = dec.is_load | dec.is_store;
  assign aligned    = is_aligned(dec.size, Result[1:0]);
  assign unused_ins = ^{Ins[25:21], Ins[10:0]};

  // In IDLE the aligner steers the incoming store; in BUSY it extracts the pending load.
  assign al_size = (state_q == ST_BUSY) ? size_q : dec.size;
  assign al_lane = (state_q == ST_BUSY) ? lane_q : Result[1:0];
  assign al_sext = (state_q == ST_BUSY) ? sext_q : dec.sext;

  mem_lane_align u_align (
    .size    (al_size),
    .lane    (al_lane),
    .sext    (al_sext),
    .st_data (Rdata2),
    .rd_data (MemRdata),
    .be      (al_be),
    .wdata   (al_wdata),
    .ld_data (al_ld)
  );

  // Next-state and next-output computation; pulses default low, everything else holds.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    sext_d      = sext_q;
    lane_d      = lane_q;
    dest_d      = dest_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_reg_d    = wb_reg_q;
    wdata_d     = wdata_q;
    addr_err_d  = 1'b0;
    bus_err_d   = 1'b0;
    bad_addr_d  = bad_addr_q;
    stall_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Valid) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_reg_d   = Ins[15:11];
            wdata_d    = Result;
          end else if (!aligned) begin
            addr_err_d = 1'b1;
            bad_addr_d = Result;
          end else begin
            stall_c     = 1'b1;
            state_d     = ST_BUSY;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = dec.is_store;
            mem_addr_d  = {Result[31:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
            size_d      = dec.size;
            sext_d      = dec.sext;
            lane_d      = Result[1:0];
            dest_d      = dec.is_store ? 5'd0 : Ins[20:16];
          end
        end
      end
      default: begin
        cnt_d = cnt_q + 8'd1;
        if (MemAck) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_reg_d   = dest_q;
          wdata_d    = mem_we_q ? 32'd0 : al_ld;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          bus_err_d  = 1'b1;
          bad_addr_d = mem_addr_q;
        end else begin
          stall_c = 1'b1;
        end
      end
    endcase
  end

  // All state and registered outputs; synchronous reset returns everything to zero/IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      size_q      <= SZ_BYTE;
      sext_q      <= 1'b0;
      lane_q      <= 2'd0;
      dest_q      <= 5'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      wb_valid_q  <= 1'b0;
      wb_reg_q    <= 5'd0;
      wdata_q     <= 32'd0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      bad_addr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      lane_q      <= lane_d;
      dest_q      <= dest_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_reg_q    <= wb_reg_d;
      wdata_q     <= wdata_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
      bad_addr_q  <= bad_addr_d;
    end
  end

  assign Stall    = stall_c;
  assign MemReq   = mem_req_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemBe    = mem_be_q;
  assign MemWdata = mem_wdata_q;
  assign WbValid  = wb_valid_q;
  assign WbReg    = wb_reg_q;
  assign Wdata    = wdata_q;
  assign AddrErr  = addr_err_q;
  assign BusErr   = bus_err_q;
  assign BadAddr  = bad_addr_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed and randomized bench for mem_access against a transaction-level model
module tb_mem_access;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Valid;
  logic [31:0] Ins, Result, Rdata2;
  logic        Stall, MemReq, MemWe;
  logic [31:0] MemAddr, MemWdata;
  logic [3:0]  MemBe;
  logic        MemAck;
  logic [31:0] MemRdata;
  logic        WbValid;
  logic [4:0]  WbReg;
  logic [31:0] Wdata;
  logic        AddrErr, BusErr;
  logic [31:0] BadAddr;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;
  bit hold   = 1'b0;

  mem_access #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .Valid(Valid), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe),
    .MemWdata(MemWdata), .MemAck(MemAck), .MemRdata(MemRdata), .WbValid(WbValid),
    .WbReg(WbReg), .Wdata(Wdata), .AddrErr(AddrErr), .BusErr(BusErr), .BadAddr(BadAddr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Access width in bytes for an opcode, 0 for non-memory ops.
  function automatic int nbytes_of(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] rd, input int lane, input int nb, input bit sgn);
    longint v;
    v = (longint'(rd) >> (8 * lane)) & ((longint'(1) << (8 * nb)) - 1);
    if (sgn && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  // Transaction-level model: one pending access, its age, and the expected registered outputs.
  bit          m_pend = 0;
  int          m_age = 0, m_lane = 0, m_nb = 0;
  bit          m_sgn = 0, m_st = 0;
  logic [4:0]  m_dest = 0;
  logic        e_req = 0, e_we = 0, e_wbv = 0, e_aerr = 0, e_berr = 0;
  logic [31:0] e_addr = 0, e_bus_wd = 0, e_wdata = 0, e_bad = 0;
  logic [3:0]  e_be = 0;
  logic [4:0]  e_wbreg = 0;

  always @(posedge CLK) begin
    int nb;
    if (RST) begin
      m_pend = 0; m_age = 0;
      e_req = 0; e_we = 0; e_wbv = 0; e_aerr = 0; e_berr = 0;
      e_addr = 0; e_bus_wd = 0; e_wdata = 0; e_bad = 0; e_be = 0; e_wbreg = 0;
    end else begin
      e_wbv = 0; e_aerr = 0; e_berr = 0;
      if (m_pend) begin
        if (MemAck) begin
          m_pend = 0; e_req = 0; e_wbv = 1;
          if (m_st) begin e_wbreg = 0; e_wdata = 0; end
          else begin e_wbreg = m_dest; e_wdata = load_val(MemRdata, m_lane, m_nb, m_sgn); end
        end else if (m_age == TO - 1) begin
          m_pend = 0; e_req = 0; e_berr = 1; e_bad = e_addr;
        end else begin
          m_age++;
        end
      end else if (Valid) begin
        nb = nbytes_of(Ins[31:26]);
        if (nb == 0) begin
          e_wbv = 1; e_wdata = Result; e_wbreg = Ins[15:11];
        end else if (int'(Result[1:0]) % nb != 0) begin
          e_aerr = 1; e_bad = Result;
        end else begin
          m_pend = 1; m_age = 0; m_nb = nb; m_lane = int'(Result[1:0]);
          m_st = Ins[31:26] >= 6'h28;
          m_sgn = (Ins[31:26] == 6'h20) || (Ins[31:26] == 6'h21);
          m_dest = m_st ? 5'd0 : Ins[20:16];
          e_req = 1; e_we = m_st; e_addr = Result & 32'hFFFF_FFFC;
          e_be = 4'(((1 << nb) - 1) << m_lane);
          for (int k = 0; k < 4; k++) e_bus_wd[8*k +: 8] = Rdata2[8*(k % nb) +: 8];
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge CLK) begin
    logic exp_stall;
    int nb;
    if (cmp_on) begin
      nb = nbytes_of(Ins[31:26]);
      if (m_pend) exp_stall = !MemAck && (m_age != TO - 1);
      else exp_stall = Valid && nb != 0 && (int'(Result[1:0]) % nb == 0);
      chk("stall", Stall, exp_stall);
      chk("memreq", MemReq, e_req);
      chk("wbvalid", WbValid, e_wbv);
      chk("addrerr", AddrErr, e_aerr);
      chk("buserr", BusErr, e_berr);
      chk("badaddr", BadAddr, e_bad);
      if (e_req) begin
        chk("memaddr", MemAddr, e_addr);
        chk("membe", MemBe, e_be);
        chk("memwdata", MemWdata, e_bus_wd);
        chk("memwe", MemWe, e_we);
      end
      if (e_wbv) begin
        chk("wbreg", WbReg, e_wbreg);
        chk("wdata", Wdata, e_wdata);
      end
      hold = exp_stall;
    end
  end

  logic [5:0] ops [10] = '{6'h00, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

  initial begin
    RST = 1; Valid = 0; Ins = 0; Result = 0; Rdata2 = 0; MemAck = 0; MemRdata = 0;
    tick; tick;
    RST = 0; cmp_on = 1;
    chk("rst_stall", Stall, 0);   chk("rst_req", MemReq, 0);   chk("rst_we", MemWe, 0);
    chk("rst_addr", MemAddr, 0);  chk("rst_be", MemBe, 0);     chk("rst_wd", MemWdata, 0);
    chk("rst_wbv", WbValid, 0);   chk("rst_wbreg", WbReg, 0);  chk("rst_wdata", Wdata, 0);
    chk("rst_aerr", AddrErr, 0);  chk("rst_berr", BusErr, 0);  chk("rst_bad", BadAddr, 0);

    // ALU pass-through
    Valid = 1; Ins = {6'h00, 5'd1, 5'd2, 5'd5, 11'd0}; Result = 32'h1234_5678;
    #1 chk("alu_stall", Stall, 0);
    tick; Valid = 0;
    chk("alu_wbv", WbValid, 1); chk("alu_wbreg", WbReg, 5);
    chk("alu_wdata", Wdata, 32'h1234_5678); chk("alu_req", MemReq, 0);

    // SB to lane 3, ack in the third busy cycle
    Valid = 1; Ins = {6'h28, 5'd0, 5'd7, 16'd0}; Result = 32'h0000_0103; Rdata2 = 32'h0000_00AB;
    #1 chk("sb_stall_comb", Stall, 1);
    tick;
    chk("sb_req", MemReq, 1); chk("sb_addr", MemAddr, 32'h100); chk("sb_be", MemBe, 4'b1000);
    chk("sb_wd", MemWdata, 32'hABAB_ABAB); chk("sb_we", MemWe, 1);
    tick; tick; MemAck = 1;
    #1 chk("sb_stall_ack", Stall, 0);
    tick; MemAck = 0;
    // back-to-back: LH presented in the cycle after the ack
    Valid = 1; Ins = {6'h21, 5'd0, 5'd9, 16'd0}; Result = 32'h202;
    chk("sb_wbv", WbValid, 1); chk("sb_wbreg", WbReg, 0); chk("sb_wdata", Wdata, 0); chk("sb_reqoff", MemReq, 0);
    #1 chk("lh_stall", Stall, 1);
    tick; MemAck = 1; MemRdata = 32'h8001_7FFF;
    tick; MemAck = 0;
    chk("lh_wbv", WbValid, 1); chk("lh_wbreg", WbReg, 9); chk("lh_wdata", Wdata, 32'hFFFF_8001);
    Ins = {6'h25, 5'd0, 5'd10, 16'd0};
    tick; MemAck = 1;
    tick; MemAck = 0; Valid = 0;
    chk("lhu_wdata", Wdata, 32'h0000_8001);

    // LW immediate ack: WbValid exactly two edges after acceptance
    Valid = 1; Ins = {6'h23, 5'd0, 5'd11, 16'd0}; Result = 32'h300; MemRdata = 32'hCAFE_F00D;
    tick; MemAck = 1;
    chk("lw_wbv_early", WbValid, 0);
    tick; MemAck = 0; Valid = 0;
    chk("lw_wbv", WbValid, 1); chk("lw_wdata", Wdata, 32'hCAFE_F00D);

    // misaligned LW
    Valid = 1; Result = 32'h6;
    #1 chk("mis_stall", Stall, 0);
    tick; Valid = 0;
    chk("mis_aerr", AddrErr, 1); chk("mis_bad", BadAddr, 32'h6); chk("mis_req", MemReq, 0); chk("mis_wbv", WbValid, 0);
    tick;
    chk("mis_aerr_pulse", AddrErr, 0);

    // timeout with no ack, then a late ack
    Valid = 1; Ins = {6'h23, 5'd0, 5'd3, 16'd0}; Result = 32'h40;
    tick;
    for (int i = 0; i < TO; i++) begin
      chk("to_req", MemReq, 1);
      chk("to_stall", Stall, (i == TO - 1) ? 0 : 1);
      if (i < TO - 1) tick;
    end
    Valid = 0;
    tick;
    chk("to_berr", BusErr, 1); chk("to_req_off", MemReq, 0); chk("to_bad", BadAddr, 32'h40); chk("to_wbv", WbValid, 0);
    MemAck = 1;
    tick; MemAck = 0;
    chk("late_ack_wbv", WbValid, 0); chk("late_ack_berr", BusErr, 0);

    // ack on the last busy cycle wins over the timeout
    Valid = 1; MemRdata = 32'h1122_3344;
    tick; tick; tick; tick; MemAck = 1; Valid = 0;
    tick; MemAck = 0;
    chk("to_ack_wbv", WbValid, 1); chk("to_ack_berr", BusErr, 0); chk("to_ack_wdata", Wdata, 32'h1122_3344);

    // reset in BUSY
    Valid = 1; Ins = {6'h23, 5'd0, 5'd4, 16'd0}; Result = 32'h80;
    tick;
    chk("rb_req", MemReq, 1);
    RST = 1;
    tick; RST = 0; Valid = 0;
    chk("rb_req_off", MemReq, 0); chk("rb_addr", MemAddr, 0); chk("rb_bad", BadAddr, 0); chk("rb_wdata", Wdata, 0);
    MemAck = 1;
    tick; MemAck = 0;
    chk("rb_ack_wbv", WbValid, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tick;
      RST = ($urandom_range(0, 249) == 0);
      MemAck = ($urandom_range(0, 3) == 0);
      MemRdata = $urandom;
      if (!hold) begin
        Valid = ($urandom_range(0, 4) != 0);
        Ins = {ops[$urandom_range(0, 9)], 26'($urandom)};
        Result = $urandom;
        Rdata2 = $urandom;
      end
    end
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
